serial_magnitude_comparator: RTL and testbench



---
 rtl/serial_magnitude_comparator.sv | 148 ++++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial W-bit unsigned magnitude comparator: one 1-bit compare slice, MSB first.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN finishes on the first differing bit.
module serial_magnitude_comparator #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         greater,
    output logic         equal,
    output logic         lesser
);

    localparam int unsigned    CW      = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CntLoad = CW'(W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  sa_q, sa_d;
    logic [W-1:0]  sb_q, sb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          decided_q, decided_d;
    logic          part_gt_q, part_gt_d;
    logic          part_lt_q, part_lt_d;
    logic          greater_q, greater_d;
    logic          equal_q, equal_d;
    logic          lesser_q, lesser_d;

    // 1-bit compare slice on the current MSBs
    logic bit_a, bit_b;
    logic bit_gt, bit_eq, bit_lt;

    assign bit_a  = sa_q[W-1];
    assign bit_b  = sb_q[W-1];
    assign bit_gt = bit_a & ~bit_b;
    assign bit_eq = ~(bit_a ^ bit_b);
    assign bit_lt = ~bit_a & bit_b;

    // Partial result including this cycle's bit; frozen once a difference was seen
    logic new_gt, new_lt, new_decided;
    logic last_bit, exit_shift;

    assign new_gt      = decided_q ? part_gt_q : bit_gt;
    assign new_lt      = decided_q ? part_lt_q : bit_lt;
    assign new_decided = decided_q | ~bit_eq;
    assign last_bit    = (cnt_q == '0);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign exit_shift = last_bit | (~decided_q & ~bit_eq);
`else
    assign exit_shift = last_bit;
`endif

    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        part_gt_d = part_gt_q;
        part_lt_d = part_lt_q;
        greater_d = greater_q;
        equal_d   = equal_q;
        lesser_d  = lesser_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    sa_d      = a;
                    sb_d      = b;
                    cnt_d     = CntLoad;
                    decided_d = 1'b0;
                    part_gt_d = 1'b0;
                    part_lt_d = 1'b0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                sa_d      = sa_q << 1;
                sb_d      = sb_q << 1;
                cnt_d     = cnt_q - CW'(1);
                decided_d = new_decided;
                part_gt_d = new_gt;
                part_lt_d = new_lt;
                if (exit_shift) begin
                    greater_d = new_gt;
                    lesser_d  = new_lt;
                    equal_d   = ~new_gt & ~new_lt;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sa_q      <= '0;
            sb_q      <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            part_gt_q <= 1'b0;
            part_lt_q <= 1'b0;
            greater_q <= 1'b0;
            equal_q   <= 1'b0;
            lesser_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            part_gt_q <= part_gt_d;
            part_lt_q <= part_lt_d;
            greater_q <= greater_d;
            equal_q   <= equal_d;
            lesser_q  <= lesser_d;
        end
    end

    assign busy    = (state_q == StShift);
    assign done    = (state_q == StDone);
    assign greater = greater_q;
    assign equal   = equal_q;
    assign lesser  = lesser_q;

    a_result_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        done |-> $onehot({greater, equal, lesser}));

    a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(busy && done));

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator (W = 8), table-driven plus corner sequences.
module tb_serial_magnitude_comparator;

    localparam int unsigned W = 8;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EarlyExit = 1'b1;
`else
    localparam bit EarlyExit = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         greater;
    logic         equal;
    logic         lesser;

    serial_magnitude_comparator #(.W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .greater(greater),
        .equal  (equal),
        .lesser (lesser)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         eg;
        logic         ee;
        logic         el;
        int           lat_full;
        int           lat_early;
    } vec_t;

    vec_t vecs[11];

    int   tests;
    int   fails;
    logic prev_g, prev_e, prev_l;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch one compare from IDLE and check handshake, latency and result.
    task automatic do_compare(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic eg, input logic ee, input logic el, input int lat);
        int cyc;
        int hold_err;
        @(negedge clk);
        a     = va;
        b     = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~va;
        b     = ~vb;
        check({name, "/busy_on"}, 32'(busy), 32'd1);
        cyc      = 0;
        hold_err = 0;
        while (done !== 1'b1 && cyc < 20) begin
            if ({greater, equal, lesser} !== {prev_g, prev_e, prev_l}) hold_err++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, "/latency"}, 32'(cyc), 32'(lat));
        check({name, "/result"}, 32'({greater, equal, lesser}), 32'({eg, ee, el}));
        check({name, "/busy_at_done"}, 32'(busy), 32'd0);
        check({name, "/hold_before"}, 32'(hold_err), 32'd0);
        @(posedge clk);
        #1;
        check({name, "/done_width"}, 32'(done), 32'd0);
        check({name, "/hold_after"}, 32'({greater, equal, lesser}), 32'({eg, ee, el}));
        prev_g = eg;
        prev_e = ee;
        prev_l = el;
    endtask

    initial begin
        int cyc;
        int n;
        int ndone;
        int wide;
        int done_at[$];

        vecs[0]  = '{"eq_a5",   8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 8, 8};
        vecs[1]  = '{"msb_gt",  8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 8, 1};
        vecs[2]  = '{"lsb_lt",  8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 8, 8};
        vecs[3]  = '{"b5_lt",   8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 8, 3};
        vecs[4]  = '{"lsb_gt",  8'h03, 8'h02, 1'b1, 1'b0, 1'b0, 8, 8};
        vecs[5]  = '{"ff_00",   8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 8, 1};
        vecs[6]  = '{"00_ff",   8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 8, 1};
        vecs[7]  = '{"5a_5b",   8'h5A, 8'h5B, 1'b0, 1'b0, 1'b1, 8, 8};
        vecs[8]  = '{"c3_c1",   8'hC3, 8'hC1, 1'b1, 1'b0, 1'b0, 8, 7};
        vecs[9]  = '{"eq_zero", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8, 8};
        vecs[10] = '{"7f_80",   8'h7F, 8'h80, 1'b0, 1'b0, 1'b1, 8, 1};

        tests  = 0;
        fails  = 0;
        prev_g = 1'b0;
        prev_e = 1'b0;
        prev_l = 1'b0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset/outs", 32'({busy, done, greater, equal, lesser}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset/idle", 32'({busy, done, greater, equal, lesser}), 32'd0);

        for (int i = 0; i < 11; i++) begin
            do_compare(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].eg, vecs[i].ee, vecs[i].el,
                       EarlyExit ? vecs[i].lat_early : vecs[i].lat_full);
        end

        // Reset in the middle of a full-length compare; previous result is lesser=1
        @(negedge clk);
        a     = 8'h00;
        b     = 8'h01;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst/outs", 32'({busy, done, greater, equal, lesser}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        check("midrst/no_done", 32'(ndone), 32'd0);
        prev_g = 1'b0;
        prev_e = 1'b0;
        prev_l = 1'b0;
        do_compare("after_rst", 8'h03, 8'h02, 1'b1, 1'b0, 1'b0, 8);

        // Start re-pulsed with different operands while busy must be ignored
        @(negedge clk);
        a     = 8'h10;
        b     = 8'h20;
        start = 1'b1;
        @(posedge clk);
        #1;
        a   = 8'hFF;
        b   = 8'h00;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check("ign/latency", 32'(cyc), EarlyExit ? 32'd3 : 32'd8);
        check("ign/result", 32'({greater, equal, lesser}), 32'b001);
        ndone = 0;
        repeat (14) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        check("ign/no_second_done", 32'(ndone), 32'd0);

        // Start held high: accepts every W+2 cycles, done always one cycle wide
        @(negedge clk);
        a     = 8'h00;
        b     = 8'h01;
        start = 1'b1;
        n     = 0;
        wide  = 0;
        for (int i = 0; i < 30; i++) begin
            logic was_done;
            was_done = done;
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) begin
                done_at.push_back(n);
                if (was_done === 1'b1) wide++;
            end
        end
        start = 1'b0;
        check("b2b/count", 32'(done_at.size()), 32'd3);
        if (done_at.size() >= 3) begin
            check("b2b/first", 32'(done_at[0]), 32'd9);
            check("b2b/second", 32'(done_at[1]), 32'd19);
            check("b2b/third", 32'(done_at[2]), 32'd29);
        end
        check("b2b/width", 32'(wide), 32'd0);
        check("b2b/result", 32'({greater, equal, lesser}), 32'b001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
